rename_recovery_sequencer: RTL and testbench

Control block for the register renamer's recovery paths. After reset it sequences the 64-entry table initialisation (spec-table identity map and free-list fill), then serves flush requests. For each flush it walks the speculatively renamed IDs from newest to oldest and issues one revert per cycle, so every discarded rename is undone in reverse program order. Sits beside the renamer; it drives the init_clear/clear_index and rename_revert/revert_id inputs that the renamer consumes from gc.

---
 rtl/rename_recovery_sequencer_if.sv | 34 +++
 rtl/rename_recovery_sequencer.sv | 140 ++++++++++++++
 tb/tb_rename_recovery_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rename_recovery_sequencer_if.sv
// Recovery-sequencer bus: init-clear outputs, flush request/ack handshake and
// the per-cycle revert strobe toward the renamer.
interface rename_recovery_sequencer_if #(
  parameter int unsigned NUM_IDS = 8
);
  localparam int unsigned ID_W = $clog2(NUM_IDS);

  logic            init_clear;
  logic [5:0]      clear_index;
  logic            init_done;
  logic            flush_req;
  logic [ID_W-1:0] flush_oldest_id;
  logic [ID_W-1:0] flush_next_id;
  logic            flush_full;
  logic            revert_ready;
  logic            rename_revert;
  logic [ID_W-1:0] revert_id;
  logic            rename_stall;
  logic            flush_ack;

  // Requester / renamer side
  modport master (
    input  init_clear, clear_index, init_done, rename_revert, revert_id,
           rename_stall, flush_ack,
    output flush_req, flush_oldest_id, flush_next_id, flush_full, revert_ready
  );

  // Sequencer side
  modport slave (
    output init_clear, clear_index, init_done, rename_revert, revert_id,
           rename_stall, flush_ack,
    input  flush_req, flush_oldest_id, flush_next_id, flush_full, revert_ready
  );
endinterface

// File: rtl/rename_recovery_sequencer.sv
// Sequences post-reset rename-table init, then undoes flushed renames newest->oldest.
// Optional macro RENAME_RECOVERY_PERF_EN adds flush_count / revert_cycles counters.
module rename_recovery_sequencer #(
  parameter int unsigned NUM_IDS     = 8,
  parameter int unsigned CLEAR_DEPTH = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  rename_recovery_sequencer_if.slave        bus
`ifdef RENAME_RECOVERY_PERF_EN
  ,
  output logic [31:0]                       flush_count,
  output logic [31:0]                       revert_cycles
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_IDS);
  localparam int unsigned CNT_W = ID_W + 1;
  localparam int unsigned CLR_W = 6;

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_REVERT = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CLR_W-1:0] clear_index;
  logic             init_done;
  logic [ID_W-1:0]  cursor;
  logic [CNT_W-1:0] remain;
  logic             ack_zero;

  logic [ID_W-1:0]  oldest_c;
  logic [ID_W-1:0]  next_c;
  logic [CNT_W-1:0] req_count_c;
  logic             last_clear_c;
  logic             accept_c;
  logic             fire_c;

  // Request decode: full flag overrides the modular distance
  always_comb begin
    oldest_c     = ID_W'(bus.flush_oldest_id);
    next_c       = ID_W'(bus.flush_next_id);
    req_count_c  = bus.flush_full ? CNT_W'(NUM_IDS) : CNT_W'(ID_W'(next_c - oldest_c));
    last_clear_c = (clear_index == CLR_W'(CLEAR_DEPTH - 1));
    accept_c     = (state == S_IDLE) && bus.flush_req;
    fire_c       = (state == S_REVERT) && bus.revert_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_CLEAR;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR:  if (last_clear_c) state_nx = S_IDLE;
      S_IDLE: begin
        if (bus.flush_req) begin
          if (req_count_c == '0) state_nx = S_ACK;
          else                   state_nx = S_REVERT;
        end
      end
      S_REVERT: if (fire_c && (remain == CNT_W'(1))) state_nx = S_ACK;
      S_ACK:    state_nx = S_IDLE;
      default:  state_nx = S_CLEAR;
    endcase
  end

  // Init index, flush cursor and remaining-revert count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clear_index <= '0;
      init_done   <= 1'b0;
      cursor      <= '0;
      remain      <= '0;
      ack_zero    <= 1'b0;
    end else begin
      if (state == S_CLEAR) begin
        clear_index <= last_clear_c ? '0 : clear_index + CLR_W'(1);
        if (last_clear_c) init_done <= 1'b1;
      end
      if (accept_c) begin
        cursor   <= next_c - ID_W'(1);
        remain   <= req_count_c;
        ack_zero <= (req_count_c == '0);
      end else if (fire_c) begin
        cursor <= cursor - ID_W'(1);
        remain <= remain - CNT_W'(1);
      end
    end
  end

  // An empty flush acks without ever stalling decode
  always_comb begin
    bus.init_clear    = 1'b0;
    bus.clear_index   = clear_index;
    bus.init_done     = init_done;
    bus.rename_revert = 1'b0;
    bus.revert_id     = '0;
    bus.rename_stall  = 1'b0;
    bus.flush_ack     = 1'b0;
    case (state)
      S_CLEAR: begin
        bus.init_clear   = 1'b1;
        bus.rename_stall = 1'b1;
      end
      S_REVERT: begin
        bus.rename_revert = fire_c;
        bus.revert_id     = cursor;
        bus.rename_stall  = 1'b1;
      end
      S_ACK: begin
        bus.flush_ack    = 1'b1;
        bus.rename_stall = !ack_zero;
      end
      default: ;
    endcase
  end

`ifdef RENAME_RECOVERY_PERF_EN
  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_count   <= '0;
      revert_cycles <= '0;
    end else begin
      if ((state == S_ACK) && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
      if ((state == S_REVERT) && (revert_cycles != 32'hFFFF_FFFF))
        revert_cycles <= revert_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_recovery_sequencer.sv
// Scoreboard bench for rename_recovery_sequencer: expected clear/revert/ack events
// are queued by stimulus and popped by a negedge monitor.
module tb_rename_recovery_sequencer;

  localparam logic [1:0] K_CLR = 2'd0;
  localparam logic [1:0] K_REV = 2'd1;
  localparam logic [1:0] K_ACK = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [5:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_flush = 0;
  exp_t q[$];
  logic [2:0] exp_ids [8];

  always #5 clk = ~clk;

  rename_recovery_sequencer_if #(.NUM_IDS(8)) bus ();

`ifdef RENAME_RECOVERY_PERF_EN
  logic [31:0] flush_count;
  logic [31:0] revert_cycles;
  rename_recovery_sequencer #(.NUM_IDS(8), .CLEAR_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .flush_count(flush_count), .revert_cycles(revert_cycles)
  );
`else
  rename_recovery_sequencer #(.NUM_IDS(8), .CLEAR_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input logic [5:0] val);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d val %0d expected nothing (t=%0t)",
               kind, val, $time);
    end else begin
      e = q.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        errors++;
        $display("FAIL event_order: got kind %0d val %0d expected kind %0d val %0d (t=%0t)",
                 kind, val, e.kind, e.val, $time);
      end
    end
  endtask

  // Monitor: every presented init/revert/ack event must match the queue head
  always @(negedge clk) begin
    if (rst) begin
      chk("clear_revert_overlap", 32'(bus.init_clear & bus.rename_revert), 32'd0);
      if (bus.init_clear)    pop_cmp(K_CLR, bus.clear_index);
      if (bus.rename_revert) pop_cmp(K_REV, 6'(bus.revert_id));
      if (bus.flush_ack)     pop_cmp(K_ACK, 6'd0);
    end
  end

  task automatic apply_reset();
    rst = 1'b0;
    #2;
    chk("rst_init_clear",    32'(bus.init_clear),    32'd1);
    chk("rst_clear_index",   32'(bus.clear_index),   32'd0);
    chk("rst_init_done",     32'(bus.init_done),     32'd0);
    chk("rst_rename_revert", 32'(bus.rename_revert), 32'd0);
    chk("rst_revert_id",     32'(bus.revert_id),     32'd0);
    chk("rst_flush_ack",     32'(bus.flush_ack),     32'd0);
    chk("rst_rename_stall",  32'(bus.rename_stall),  32'd1);
`ifdef RENAME_RECOVERY_PERF_EN
    chk("rst_flush_count",   flush_count,   32'd0);
    chk("rst_revert_cycles", revert_cycles, 32'd0);
`endif
    chk("queue_empty_at_reset", 32'(q.size()), 32'd0);
    q.delete();
    for (int i = 0; i < 64; i++) q.push_back('{kind: K_CLR, val: 6'(i)});
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_init();
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.init_done) break;
    end
    chk("init_done",         32'(bus.init_done),    32'd1);
    chk("idle_init_clear",   32'(bus.init_clear),   32'd0);
    chk("idle_clear_index",  32'(bus.clear_index),  32'd0);
    chk("idle_rename_stall", 32'(bus.rename_stall), 32'd0);
  endtask

  task automatic do_flush(input string name, input logic [2:0] oldest, input logic [2:0] nxt,
                          input logic full, input int n, input logic [7:0] pat,
                          input int patlen, input logic exp_stall);
    logic saw_stall;
    logic got_ack;
    int   idx;
    for (int i = 0; i < n; i++) q.push_back('{kind: K_REV, val: 6'(exp_ids[i])});
    q.push_back('{kind: K_ACK, val: 6'd0});
    n_flush++;
    @(posedge clk);
    #1;
    bus.flush_oldest_id = oldest;
    bus.flush_next_id   = nxt;
    bus.flush_full      = full;
    bus.revert_ready    = 1'b1;
    bus.flush_req       = 1'b1;
    saw_stall = 1'b0;
    got_ack   = 1'b0;
    idx       = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (bus.rename_stall) saw_stall = 1'b1;
      if (bus.flush_ack) begin
        got_ack = 1'b1;
        break;
      end
      if (bus.rename_stall && bus.init_done) begin
        bus.revert_ready = (idx < patlen) ? pat[idx] : 1'b1;
        idx++;
      end
    end
    bus.flush_req    = 1'b0;
    bus.revert_ready = 1'b1;
    chk({name, "_ack"}, 32'(got_ack), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_all_events_seen"}, 32'(q.size()), 32'd0);
    chk({name, "_stall"}, 32'(saw_stall), 32'(exp_stall));
    q.delete();
  endtask

  initial begin
    bus.flush_req       = 1'b0;
    bus.flush_oldest_id = '0;
    bus.flush_next_id   = '0;
    bus.flush_full      = 1'b0;
    bus.revert_ready    = 1'b1;

    apply_reset();
    wait_init();

    exp_ids = '{3'd4, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    do_flush("basic", 3'd2, 3'd5, 1'b0, 3, 8'hFF, 0, 1'b1);

    exp_ids = '{3'd0, 3'd7, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    do_flush("wrap", 3'd6, 3'd1, 1'b0, 3, 8'hFF, 0, 1'b1);

    exp_ids = '{3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
    do_flush("full", 3'd3, 3'd3, 1'b1, 8, 8'hFF, 0, 1'b1);

    // revert_ready sequence 1,0,0,1,1 (bit 0 first)
    exp_ids = '{3'd4, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    do_flush("ready_toggle", 3'd2, 3'd5, 1'b0, 3, 8'b0001_1001, 5, 1'b1);

    do_flush("empty", 3'd5, 3'd5, 1'b0, 0, 8'hFF, 0, 1'b0);

    // Flush raised during CLEAR is held and served after init
    apply_reset();
    exp_ids = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    do_flush("during_clear", 3'd0, 3'd2, 1'b0, 2, 8'hFF, 0, 1'b1);
    chk("during_clear_init_done", 32'(bus.init_done), 32'd1);

`ifdef RENAME_RECOVERY_PERF_EN
    chk("perf_flush_count", flush_count, 32'(n_flush - 5));
`endif

    // Reset in the middle of an 8-ID flush after two reverts
    q.push_back('{kind: K_REV, val: 6'd2});
    q.push_back('{kind: K_REV, val: 6'd1});
    @(posedge clk);
    #1;
    bus.flush_oldest_id = 3'd3;
    bus.flush_next_id   = 3'd3;
    bus.flush_full      = 1'b1;
    bus.revert_ready    = 1'b1;
    bus.flush_req       = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        if (bus.rename_stall) begin
          seen = 1'b1;
          break;
        end
      end
      chk("mid_revert_entered", 32'(seen), 32'd1);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    apply_reset();
    wait_init();

    exp_ids = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    do_flush("after_reset", 3'd1, 3'd4, 1'b0, 3, 8'hFF, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
